// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR conversion path: sequencer state encoding and
// the default converter width. Also imported by the SAR register logic so both
// sides agree on the state codes and the bit count.
// -----------------------------------------------------------------------------
package sar_pkg;

  // Default number of SAR bits (bit trials per conversion).
  localparam int SAR_N_DEFAULT = 8;

  // Sequencer state codes.
  localparam logic [1:0] SAR_IDLE    = 2'd0;
  localparam logic [1:0] SAR_SAMPLE  = 2'd1;
  localparam logic [1:0] SAR_CONVERT = 2'd2;
  localparam logic [1:0] SAR_DONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = SAR_IDLE,
    ST_SAMPLE  = SAR_SAMPLE,
    ST_CONVERT = SAR_CONVERT,
    ST_DONE    = SAR_DONE
  } sar_state_e;

endpackage : sar_pkg

// File: rtl/sar_clk_div.sv
// -----------------------------------------------------------------------------
// sar_clk_div
// Half-period tick generator for the SAR bit clock. The counter runs while
// en_i is high and wraps to zero on the cycle it equals ratio_i, so a tick
// marks the last cycle of every (ratio_i+1)-cycle half-period.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   clr_i       synchronous clear (priority over en_i)
//   en_i        count enable
//   ratio_i     half-period length minus one
//   tick_o      current cycle is the last of a half-period
//   tick_next_o the next cycle will be the last of a half-period; lets the
//               parent register its strobe so it lines up with tick_o
// -----------------------------------------------------------------------------
module sar_clk_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] ratio_i,
  output logic             tick_o,
  output logic             tick_next_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = en_i && !clr_i && (cnt_q == ratio_i);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end
    tick_next_o = (cnt_d == ratio_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : sar_clk_div

// File: rtl/sar_conv_sequencer.sv
// -----------------------------------------------------------------------------
// sar_conv_sequencer
// Sequences one SAR conversion: a programmable sample window, N bit-trial
// periods on a divided bit clock, then a one-cycle done pulse. Supports
// single-shot and continuous modes, abort, and overrun flagging. Every output
// is a flop loaded from the next-state values, so outputs change on the same
// edge as the state and never glitch.
//
// Ports:
//   clk_in        system clock
//   rst_n         asynchronous active-low reset
//   start         conversion request (level, sampled in IDLE and DONE)
//   mode_cont     1 = back-to-back conversions
//   abort         return to IDLE at the next edge, no done pulse
//   div_ratio     bit-clock half-period = div_ratio+1 cycles
//   sample_cycles sample window = sample_cycles+1 cycles
//   busy          high in SAMPLE, CONVERT, DONE
//   sample_en     track/hold enable, high in SAMPLE
//   bit_clk       high in the first half of each bit period
//   bit_strobe    pulse on the last cycle of each bit period
//   bit_idx       current trial bit, N-1 down to 0
//   done          one-cycle conversion-complete pulse
//   overrun       one-cycle pulse after start seen in SAMPLE/CONVERT
// -----------------------------------------------------------------------------
module sar_conv_sequencer
  import sar_pkg::*;
#(
  parameter int N      = SAR_N_DEFAULT,
  parameter int DIV_W  = 4,
  parameter int SAMP_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode_cont,
  input  logic                 abort,
  input  logic [DIV_W-1:0]     div_ratio,
  input  logic [SAMP_W-1:0]    sample_cycles,
  output logic                 busy,
  output logic                 sample_en,
  output logic                 bit_clk,
  output logic                 bit_strobe,
  output logic [$clog2(N)-1:0] bit_idx,
  output logic                 done,
  output logic                 overrun
);

  localparam int               IDX_W   = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(N - 1);

  sar_state_e        state_q, state_d;
  logic [DIV_W-1:0]  ratio_q, ratio_d;
  logic [SAMP_W-1:0] samp_len_q, samp_len_d;
  logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
  logic              half_q, half_d;       // 0 = first (high) half of bit period
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              overrun_d;

  logic busy_q, sample_en_q, bit_clk_q, bit_strobe_q, done_q, overrun_q;

  logic div_tick, div_tick_next;

  // Divider held clear outside CONVERT so every conversion starts at count 0.
  sar_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk         (clk_in),
    .rst_n       (rst_n),
    .clr_i       ((state_q != ST_CONVERT) || abort),
    .en_i        (state_q == ST_CONVERT),
    .ratio_i     (ratio_q),
    .tick_o      (div_tick),
    .tick_next_o (div_tick_next)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    ratio_d    = ratio_q;
    samp_len_d = samp_len_q;
    samp_cnt_d = samp_cnt_q;
    half_d     = half_q;
    idx_d      = idx_q;
    overrun_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_SAMPLE;
          ratio_d    = div_ratio;
          samp_len_d = sample_cycles;
          samp_cnt_d = '0;
        end
      end
      ST_SAMPLE: begin
        overrun_d = start;
        if (samp_cnt_q == samp_len_q) begin
          state_d = ST_CONVERT;
          half_d  = 1'b0;
          idx_d   = IDX_MSB;
        end else begin
          samp_cnt_d = samp_cnt_q + SAMP_W'(1);
        end
      end
      ST_CONVERT: begin
        overrun_d = start;
        if (div_tick) begin
          half_d = ~half_q;
          // End of the low half closes the bit; the last bit ends the conversion.
          if (half_q) begin
            if (idx_q == '0) state_d = ST_DONE;
            else             idx_d   = idx_q - IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        idx_d = IDX_MSB;
        if (mode_cont || start) begin
          state_d    = ST_SAMPLE;
          ratio_d    = div_ratio;
          samp_len_d = sample_cycles;
          samp_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over every other request once a conversion is under way.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      samp_cnt_d = '0;
      half_d     = 1'b0;
      idx_d      = IDX_MSB;
      overrun_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ratio_q      <= '0;
      samp_len_q   <= '0;
      samp_cnt_q   <= '0;
      half_q       <= 1'b0;
      idx_q        <= IDX_MSB;
      busy_q       <= 1'b0;
      sample_en_q  <= 1'b0;
      bit_clk_q    <= 1'b0;
      bit_strobe_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      samp_len_q   <= samp_len_d;
      samp_cnt_q   <= samp_cnt_d;
      half_q       <= half_d;
      idx_q        <= idx_d;
      busy_q       <= (state_d != ST_IDLE);
      sample_en_q  <= (state_d == ST_SAMPLE);
      bit_clk_q    <= (state_d == ST_CONVERT) && !half_d;
      bit_strobe_q <= (state_d == ST_CONVERT) && half_d && div_tick_next;
      done_q       <= (state_d == ST_DONE);
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = busy_q;
  assign sample_en  = sample_en_q;
  assign bit_clk    = bit_clk_q;
  assign bit_strobe = bit_strobe_q;
  assign bit_idx    = idx_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule : sar_conv_sequencer

// File: tb/tb_sar_conv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sar_conv_sequencer
// Self-checking bench: a table of per-cycle vectors for the basic single-shot
// conversion, plus directed sequences for divider, continuous mode, overrun,
// abort and asynchronous reset. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at that same point.
// -----------------------------------------------------------------------------
module tb_sar_conv_sequencer;
  import sar_pkg::*;

  localparam int N      = SAR_N_DEFAULT;
  localparam int DIV_W  = 4;
  localparam int SAMP_W = 4;
  localparam int IDX_W  = $clog2(N);

  logic              clk_in = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              mode_cont = 1'b0;
  logic              abort = 1'b0;
  logic [DIV_W-1:0]  div_ratio = '0;
  logic [SAMP_W-1:0] sample_cycles = '0;
  logic              busy, sample_en, bit_clk, bit_strobe, done, overrun;
  logic [IDX_W-1:0]  bit_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk_in = ~clk_in;

  sar_conv_sequencer #(.N(N), .DIV_W(DIV_W), .SAMP_W(SAMP_W)) dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .start         (start),
    .mode_cont     (mode_cont),
    .abort         (abort),
    .div_ratio     (div_ratio),
    .sample_cycles (sample_cycles),
    .busy          (busy),
    .sample_en     (sample_en),
    .bit_clk       (bit_clk),
    .bit_strobe    (bit_strobe),
    .bit_idx       (bit_idx),
    .done          (done),
    .overrun       (overrun)
  );

  // Output bundle: {busy, sample_en, bit_clk, bit_strobe, bit_idx[2:0], done, overrun}
  typedef struct packed {
    logic       start;
    logic       mode_cont;
    logic       abort;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [9:0] pack_out(logic b, logic se, logic bc, logic bs,
                                          logic [2:0] idx, logic d, logic ov);
    return {b, se, bc, bs, idx, d, ov};
  endfunction

  function automatic logic [9:0] outs();
    return {busy, sample_en, bit_clk, bit_strobe, bit_idx, done, overrun};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (%b) expected %0d (%b)", name, act, act, exp, exp);
    end
  endtask

  // Pulse start for one cycle, then return the cycle (start edge = 0) at which
  // done is seen, or -1 if the budget runs out.
  task automatic conv_latency(input int budget, output int dcyc);
    dcyc  = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (done) begin
        dcyc = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int errs, strobes, done_cyc, k, ov_cnt, ov_cyc, dn, st, ab_cyc;
    int dcyc [3];

    // ---------------- reset ----------------
    repeat (2) @(posedge clk_in);
    #1;
    check("reset outputs", 32'(outs()), 32'(pack_out(0, 0, 0, 0, 3'd7, 0, 0)));
    #3 rst_n = 1'b1;
    tick();

    // ---------------- basic single-shot table ----------------
    // Row i: inputs during cycle i, expected outputs in cycle i+1.
    for (int i = 0; i < 22; i++) begin
      int c;
      logic b, se, bc, bs, d;
      logic [2:0] idx;
      c   = i + 1;
      b   = (c >= 1) && (c <= 20);
      se  = (c >= 1) && (c <= 3);
      bc  = (c >= 4) && (c <= 19) && (((c - 4) % 2) == 0);
      bs  = (c >= 4) && (c <= 19) && (((c - 4) % 2) == 1);
      d   = (c == 20);
      if ((c >= 4) && (c <= 19)) idx = 3'(7 - (c - 4) / 2);
      else if (c == 20)          idx = 3'd0;
      else                       idx = 3'd7;
      vecs[i].start     = (i == 0);
      vecs[i].mode_cont = 1'b0;
      vecs[i].abort     = 1'b0;
      vecs[i].exp       = pack_out(b, se, bc, bs, idx, d, 1'b0);
    end

    div_ratio     = 4'd0;
    sample_cycles = 4'd2;
    for (int i = 0; i < 22; i++) begin
      start     = vecs[i].start;
      mode_cont = vecs[i].mode_cont;
      abort     = vecs[i].abort;
      tick();
      check($sformatf("basic cycle %0d", i + 1), 32'(outs()), 32'(vecs[i].exp));
    end
    start = 1'b0;

    // ---------------- divider, ratio change mid-conversion ----------------
    div_ratio     = 4'd3;
    sample_cycles = 4'd0;
    start         = 1'b1;
    tick();                       // cycle 1: SAMPLE
    start     = 1'b0;
    div_ratio = 4'd0;             // must not affect the running conversion
    errs = 0; strobes = 0; done_cyc = -1;
    for (int c = 2; c <= 100; c++) begin
      tick();
      if (c <= 65) begin
        if (bit_clk !== (((c - 2) % 8) < 4))     errs++;
        if (bit_strobe !== (((c - 2) % 8) == 7)) errs++;
      end
      if (bit_strobe) strobes++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    check("div3 bit_clk/strobe pattern errors", 32'(errs), 32'd0);
    check("div3 strobe count", 32'(strobes), 32'd8);
    check("div3 done cycle", 32'(done_cyc), 32'd66);
    tick();
    check("div3 idle after done", 32'(outs()), 32'(pack_out(0, 0, 0, 0, 3'd7, 0, 0)));

    // ---------------- continuous mode ----------------
    div_ratio     = 4'd0;
    sample_cycles = 4'd2;
    mode_cont     = 1'b1;
    start         = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      if (k >= 2) mode_cont = 1'b0;
      if (done) begin
        dcyc[k] = c;
        k++;
        if (k == 3) break;
      end
      tick();
    end
    check("cont done count", 32'(k), 32'd3);
    check("cont spacing 1-2", 32'(dcyc[1] - dcyc[0]), 32'd20);
    check("cont spacing 2-3", 32'(dcyc[2] - dcyc[1]), 32'd20);
    tick();
    check("cont idle after mode drop", 32'(busy), 32'd0);
    mode_cont = 1'b0;

    // ---------------- overrun ----------------
    sample_cycles = 4'd1;
    start         = 1'b1;
    tick();
    start = 1'b0;
    ov_cnt = 0; ov_cyc = -1; dn = 0; done_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (overrun) begin ov_cnt++; ov_cyc = c; end
      if (done)    begin dn++; done_cyc = c; end
      start = (c == 6);
      tick();
    end
    start = 1'b0;
    check("overrun pulse count", 32'(ov_cnt), 32'd1);
    check("overrun cycle", 32'(ov_cyc), 32'd7);
    check("overrun done count", 32'(dn), 32'd1);
    check("overrun done cycle", 32'(done_cyc), 32'd19);
    check("overrun idle at end", 32'(busy), 32'd0);

    // ---------------- abort at 3rd strobe ----------------
    sample_cycles = 4'd0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    st = 0; ab_cyc = -10; dn = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == ab_cyc + 1)
        check("abort outputs", 32'(outs()), 32'(pack_out(0, 0, 0, 0, 3'd7, 0, 0)));
      if (done) dn++;
      abort = 1'b0;
      if (bit_strobe) begin
        st++;
        if (st == 3) begin
          abort  = 1'b1;
          ab_cyc = c;
        end
      end
      tick();
    end
    abort = 1'b0;
    check("abort strobe cycle", 32'(ab_cyc), 32'd7);
    check("abort no done", 32'(dn), 32'd0);
    conv_latency(100, done_cyc);
    check("restart after abort done cycle", 32'(done_cyc), 32'd18);
    tick();

    // ---------------- async reset mid-SAMPLE ----------------
    sample_cycles = 4'd5;
    start         = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre-reset in sample", 32'({busy, sample_en}), 32'b11);
    #3 rst_n = 1'b0;
    #1;
    check("async reset drop", 32'(outs()), 32'(pack_out(0, 0, 0, 0, 3'd7, 0, 0)));
    tick();
    #3;
    start = 1'b1;
    rst_n = 1'b1;
    #1;
    check("after release outputs", 32'(outs()), 32'(pack_out(0, 0, 0, 0, 3'd7, 0, 0)));
    tick();
    start = 1'b0;
    check("start accepted after release", 32'({busy, sample_en}), 32'b11);
    done_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    check("post-reset conversion done cycle", 32'(done_cyc), 32'd23);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sar_conv_sequencer
